// File: rtl/sd_delay_timer.sv
// sd_delay_timer: multi-channel prescaled delay timer for the SD controller.
//
// All channels share one free-running prescaler. Each channel runs a
// start/finish level handshake: a start level seen in IDLE latches the
// channel's delay, and the channel then counts prescaler ticks. After
// times_q+1 ticks, finish rises and stays high until the next accepted start
// or an abort. done_pulse is high for the single clk on which finish rises.
// The timer is used for command/response timeouts and for init delays.
//
// Parameters
//   COUNT_SIZE     width of each channel's delay count and times field
//   PRESCALE_SIZE  width of the prescaler compare value
//   NUM_CH         number of independent delay channels
//
// Ports
//   clk         system clock; all state changes on posedge
//   rst         asynchronous reset, active-high
//   prescale    tick period is prescale+1 clk cycles; read live
//   start       per-channel start level (handshake request)
//   abort       per-channel cancel, level-sampled
//   times       per-channel delay; channel i is [i*COUNT_SIZE +: COUNT_SIZE]
//   finish      per-channel completion level (registered)
//   done_pulse  per-channel one-clk pulse, aligned with the rise of finish
//   busy        per-channel, high while that channel is counting
`timescale 1ns/1ps

module sd_delay_timer #(
    parameter int unsigned COUNT_SIZE    = 16,
    parameter int unsigned PRESCALE_SIZE = 8,
    parameter int unsigned NUM_CH        = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PRESCALE_SIZE-1:0]     prescale,
    input  logic [NUM_CH-1:0]            start,
    input  logic [NUM_CH-1:0]            abort,
    input  logic [NUM_CH*COUNT_SIZE-1:0] times,
    output logic [NUM_CH-1:0]            finish,
    output logic [NUM_CH-1:0]            done_pulse,
    output logic [NUM_CH-1:0]            busy
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StCount = 2'd1,
        StDone  = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Shared prescaler
    // ------------------------------------------------------------------
    logic [PRESCALE_SIZE-1:0] pre_cnt_q;
    logic                     tick;

    // A >= compare rather than == means that if prescale is lowered below
    // the current count, the prescaler ticks on the next clk instead of
    // running all the way around before the next tick.
    assign tick = (pre_cnt_q >= prescale);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_q <= '0;
        end else if (tick) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_q + PRESCALE_SIZE'(1);
        end
    end

    // ------------------------------------------------------------------
    // Per-channel handshake FSMs
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_e                  state_q;
        logic [COUNT_SIZE-1:0]   count_q;
        logic [COUNT_SIZE-1:0]   times_q;
        logic                    finish_q;
        logic                    done_q;
        logic [COUNT_SIZE-1:0]   times_slice;

        assign times_slice = times[i*COUNT_SIZE +: COUNT_SIZE];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q  <= StIdle;
                count_q  <= '0;
                times_q  <= '0;
                finish_q <= 1'b0;
                done_q   <= 1'b0;
            end else begin
                done_q <= 1'b0;
                case (state_q)
                    StIdle: begin
                        count_q <= '0;
                        if (abort[i]) begin
                            finish_q <= 1'b0;
                        end else if (start[i]) begin
                            // Delay is latched here; later changes to times
                            // do not affect this run.
                            times_q  <= times_slice;
                            finish_q <= 1'b0;
                            state_q  <= StCount;
                        end
                    end
                    StCount: begin
                        if (abort[i]) begin
                            state_q <= StIdle;
                        end else if (tick) begin
                            // Compare before increment so an all-ones delay
                            // completes without the count wrapping.
                            if (count_q == times_q) begin
                                finish_q <= 1'b1;
                                done_q   <= 1'b1;
                                state_q  <= StDone;
                            end else begin
                                count_q <= count_q + COUNT_SIZE'(1);
                            end
                        end
                    end
                    StDone: begin
                        if (abort[i]) begin
                            finish_q <= 1'b0;
                            state_q  <= StIdle;
                        end else if (!start[i]) begin
                            // finish stays high until the next accepted start.
                            state_q <= StIdle;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end

        assign finish[i]     = finish_q;
        assign done_pulse[i] = done_q;
        assign busy[i]       = (state_q == StCount);
    end

endmodule

// File: tb/tb_sd_delay_timer.sv
`timescale 1ns/1ps

module tb_sd_delay_timer;

    localparam int unsigned CW  = 4;
    localparam int unsigned PW  = 8;
    localparam int unsigned NCH = 2;
    localparam int          NVEC = 24;

    logic                clk = 1'b0;
    logic                rst;
    logic [PW-1:0]       prescale;
    logic [NCH-1:0]      start;
    logic [NCH-1:0]      abort;
    logic [NCH*CW-1:0]   times;
    logic [NCH-1:0]      finish;
    logic [NCH-1:0]      done_pulse;
    logic [NCH-1:0]      busy;

    sd_delay_timer #(
        .COUNT_SIZE    (CW),
        .PRESCALE_SIZE (PW),
        .NUM_CH        (NCH)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .prescale   (prescale),
        .start      (start),
        .abort      (abort),
        .times      (times),
        .finish     (finish),
        .done_pulse (done_pulse),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Number of posedges so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard of expected done pulses: channel and the posedge they follow.
    typedef struct {
        int ch;
        int edge_n;
    } sb_t;

    sb_t            sb_q[$];
    bit             sb_en = 1'b0;
    logic [NCH-1:0] prev_done = '0;

    task automatic push(input int ch, input int edge_n);
        sb_t e;
        e.ch     = ch;
        e.edge_n = edge_n;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        sb_t e;
        if (sb_en && !rst) begin
            for (int c = 0; c < NCH; c++) begin
                if (done_pulse[c]) begin
                    check("done_pulse width", int'(prev_done[c]), 0);
                    check("done_pulse expected", (sb_q.size() > 0) ? 1 : 0, 1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        check("done_pulse channel", c, e.ch);
                        check("done_pulse edge", cyc, e.edge_n);
                    end
                end
            end
        end
        prev_done = done_pulse;
    end

    // Cycle vectors for channel 0, prescale 0; channel 1 stays idle.
    typedef struct {
        logic       st;
        logic       ab;
        logic [3:0] t0;
        logic       f;
        logic       b;
        logic       d;
    } vec_t;

    vec_t vt[NVEC];

    initial begin
        int c;

        //          st    ab    t0     fin   busy  done
        // times=3: four ticks of COUNT, then finish with pulse.
        vt[0]  = '{1'b1, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b1};
        vt[5]  = '{1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0};
        // times=0: finish on next edge; persists in IDLE; cleared on restart.
        vt[7]  = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1};
        vt[9]  = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};
        vt[10] = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};
        vt[11] = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
        vt[12] = '{1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1};
        vt[13] = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};
        // Abort with start in IDLE: stays IDLE, finish cleared.
        vt[14] = '{1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0};
        vt[15] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        // Abort at count=1 with times=5.
        vt[16] = '{1'b1, 1'b0, 4'd5, 1'b0, 1'b1, 1'b0};
        vt[17] = '{1'b0, 1'b0, 4'd5, 1'b0, 1'b1, 1'b0};
        vt[18] = '{1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0};
        vt[19] = '{1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0};
        // Abort in DONE clears finish.
        vt[20] = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
        vt[21] = '{1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1};
        vt[22] = '{1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0};
        vt[23] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};

        rst      = 1'b1;
        prescale = 8'd4;
        start    = '0;
        abort    = '0;
        times    = '0;
        #1;
        check("reset finish", int'(finish), 0);
        check("reset busy", int'(busy), 0);
        check("reset done_pulse", int'(done_pulse), 0);

        // Prescale 4 from a reset-aligned start: 3 ticks at edges 5, 10, 15.
        step(3);
        times[CW-1:0] = 4'd2;
        start[0]      = 1'b1;
        step(1);
        rst   = 1'b0;
        sb_en = 1'b1;
        c     = cyc;
        push(0, c + 15);
        step(5);
        times[CW-1:0] = 4'd9;
        step(9);
        check("p4 busy before finish", int'(busy[0]), 1);
        check("p4 finish before end", int'(finish[0]), 0);
        step(1);
        check("p4 finish at edge 15", int'(finish[0]), 1);
        step(3);
        check("p4 scoreboard drained", sb_q.size(), 0);
        start    = '0;
        prescale = 8'd0;
        step(2);

        // Table-driven vectors at prescale 0.
        sb_en = 1'b0;
        for (int i = 0; i < NVEC; i++) begin
            start[0]      = vt[i].st;
            abort[0]      = vt[i].ab;
            times[CW-1:0] = vt[i].t0;
            step(1);
            check($sformatf("vec%0d finish", i), int'(finish), int'({1'b0, vt[i].f}));
            check($sformatf("vec%0d busy", i), int'(busy), int'({1'b0, vt[i].b}));
            check($sformatf("vec%0d done_pulse", i), int'(done_pulse), int'({1'b0, vt[i].d}));
        end
        abort = '0;
        start = '0;
        step(1);
        sb_en = 1'b1;

        // Two channels started on the same edge.
        times = {4'd5, 4'd2};
        start = 2'b11;
        c     = cyc;
        push(0, c + 4);
        push(1, c + 7);
        step(3);
        check("dual busy", int'(busy), 3);
        step(5);
        check("dual finish", int'(finish), 3);
        check("dual busy after", int'(busy), 0);
        start = '0;
        step(1);
        check("dual finish persists", int'(finish), 3);
        check("dual scoreboard drained", sb_q.size(), 0);

        // All-ones delay: 16 ticks, no count wrap.
        times[CW-1:0] = 4'd15;
        start[0]      = 1'b1;
        c             = cyc;
        push(0, c + 17);
        step(16);
        check("ones busy", int'(busy[0]), 1);
        check("ones finish early", int'(finish[0]), 0);
        step(2);
        check("ones finish", int'(finish[0]), 1);
        check("ones scoreboard drained", sb_q.size(), 0);
        start = '0;
        step(1);

        // Async reset mid-count with another channel holding finish.
        times = {4'd0, 4'd10};
        start = 2'b11;
        c     = cyc;
        push(1, c + 2);
        step(4);
        check("pre-rst finish", int'(finish), 2);
        check("pre-rst busy", int'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async rst finish", int'(finish), 0);
        check("async rst busy", int'(busy), 0);
        check("async rst done_pulse", int'(done_pulse), 0);
        check("rst scoreboard drained", sb_q.size(), 0);

        // Lower prescale 7 -> 1 when pre_cnt is 5: tick on the next clk.
        prescale = 8'd7;
        times    = '0;
        start    = 2'b01;
        step(2);
        rst = 1'b0;
        c   = cyc;
        push(0, c + 6);
        step(5);
        check("p7 finish before lower", int'(finish[0]), 0);
        prescale = 8'd1;
        step(1);
        check("lowered prescale finish", int'(finish[0]), 1);
        step(2);
        check("lowered scoreboard drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
